// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared state encoding and default widths for the sequencer
package cpu_ctrl_pkg;
    localparam int PC_W_DEF = 16;
    localparam int BR_W_DEF = 11;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;
endpackage

// File: rtl/cpu_seq_ctrl_if.sv
// cpu_seq_ctrl_if: instruction and data memory handshakes of the sequencer
interface cpu_seq_ctrl_if #(
    parameter int PC_W = 16
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ready;
    logic [15:0]     imem_data;
    logic            dmem_req;
    logic            dmem_we;
    logic            dmem_ready;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_ready, imem_data, dmem_ready
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_ready, imem_data, dmem_ready
    );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: program counter with sequential increment and sign-extended branch add
module pc_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int PC_W = PC_W_DEF,
    parameter int BR_W = BR_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inc,
    input  logic            br_take,
    input  logic [BR_W-1:0] br_off,
    output logic [PC_W-1:0] pc
);
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_target;

    assign w_target = r_pc + {{(PC_W-BR_W){br_off[BR_W-1]}}, br_off};
    assign pc = r_pc;

    // increment on fetch accept, jump on a taken branch; both wrap mod 2^PC_W
    always_ff @(posedge clk) begin
        if (reset) r_pc <= RESET_PC;
        else if (inc) r_pc <= r_pc + PC_W'(1);
        else if (br_take) r_pc <= w_target;
    end
endmodule

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: handshake-aware FETCH/DECODE/EXEC/MEM/WB sequencer owning IR and PC
module cpu_seq_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int PC_W = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF),
    parameter int BR_W = BR_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    cpu_seq_ctrl_if.master  bus,
    output logic [15:0]     ir,
    input  logic            op_halt,
    input  logic            op_branch,
    input  logic            op_load,
    input  logic            op_store,
    input  logic            op_wr_rf,
    input  logic [BR_W-1:0] br_off,
    input  logic            z_flag,
    output logic            rf_we,
    output logic            wb_sel_mem,
    output logic            pc_sync_we,
    output logic [PC_W-1:0] pc,
    output logic            retire,
    output logic            halted,
    output logic [2:0]      state_dbg
);
    state_t          r_state;
    logic [15:0]     r_ir;
    logic            r_imem_req;
    logic            r_dmem_req;
    logic            r_dmem_we;
    logic            r_rf_we;
    logic            r_wb_sel_mem;
    logic            r_pc_sync_we;
    logic            r_halted;
    logic            w_ls;
    logic            w_fetch_ok;
    logic            w_mem_ok;
    logic            w_br_take;
    logic [PC_W-1:0] w_pc;

    assign w_ls       = op_load | op_store;
    assign w_fetch_ok = (r_state == FETCH) && r_imem_req && bus.imem_ready;
    assign w_mem_ok   = (r_state == MEM) && bus.dmem_ready;
    assign w_br_take  = (r_state == EXEC) && !op_halt && op_branch && z_flag;

    // retire depends on the data handshake, so it is decoded rather than registered
    assign retire = ((r_state == EXEC) && (op_halt || op_branch || !(w_ls || op_wr_rf)))
                  || (w_mem_ok && !op_load)
                  || (r_state == WB);

    assign bus.imem_req  = r_imem_req;
    assign bus.imem_addr = w_pc;
    assign bus.dmem_req  = r_dmem_req;
    assign bus.dmem_we   = r_dmem_we;
    assign ir            = r_ir;
    assign rf_we         = r_rf_we;
    assign wb_sel_mem    = r_wb_sel_mem;
    assign pc_sync_we    = r_pc_sync_we;
    assign halted        = r_halted;
    assign pc            = w_pc;
    assign state_dbg     = r_state;

    pc_unit #(.PC_W(PC_W), .BR_W(BR_W), .RESET_PC(RESET_PC)) u_pc (
        .clk     (clk),
        .reset   (reset),
        .inc     (w_fetch_ok),
        .br_take (w_br_take),
        .br_off  (br_off),
        .pc      (w_pc)
    );

    // sequencer; each control output is set on entry to the state that owns it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= FETCH;
            r_ir         <= 16'h0000;
            r_imem_req   <= 1'b0;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_rf_we      <= 1'b0;
            r_wb_sel_mem <= 1'b0;
            r_pc_sync_we <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            r_rf_we      <= 1'b0;
            r_wb_sel_mem <= 1'b0;
            r_pc_sync_we <= 1'b0;
            case (r_state)
                FETCH: begin
                    r_imem_req <= !w_fetch_ok;
                    if (w_fetch_ok) begin
                        r_ir         <= bus.imem_data;
                        r_pc_sync_we <= 1'b1;
                        r_state      <= DECODE;
                    end
                end
                DECODE: r_state <= EXEC;
                EXEC: begin
                    if (op_halt) begin
                        r_halted <= 1'b1;
                        r_state  <= HALT;
                    end else if (op_branch || !(w_ls || op_wr_rf)) begin
                        r_imem_req <= 1'b1;
                        r_state    <= FETCH;
                    end else if (w_ls) begin
                        r_dmem_req <= 1'b1;
                        r_dmem_we  <= op_store;
                        r_state    <= MEM;
                    end else begin
                        r_rf_we <= 1'b1;
                        r_state <= WB;
                    end
                end
                MEM: begin
                    if (w_mem_ok) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        if (op_load) begin
                            r_rf_we      <= 1'b1;
                            r_wb_sel_mem <= 1'b1;
                            r_state      <= WB;
                        end else begin
                            r_imem_req <= 1'b1;
                            r_state    <= FETCH;
                        end
                    end
                end
                WB: begin
                    r_imem_req <= 1'b1;
                    r_state    <= FETCH;
                end
                HALT: r_state <= HALT;
                default: r_state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb_cpu_seq_ctrl: directed scoreboard bench for the sequencer
module tb_cpu_seq_ctrl;
    import cpu_ctrl_pkg::*;

    typedef struct {
        logic [15:0] ir;
        logic [23:0] path;
        int          lat;
        logic        rf;
        logic        wbs;
        logic [15:0] pcn;
        logic        hn;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] ir;
    logic        op_halt = 1'b0, op_branch = 1'b0, op_load = 1'b0, op_store = 1'b0, op_wr_rf = 1'b0;
    logic [10:0] br_off = 11'd0;
    logic        z_flag = 1'b0;
    logic        rf_we, wb_sel_mem, pc_sync_we, retire, halted;
    logic [15:0] pc;
    logic [2:0]  state_dbg;

    int          n_chk = 0;
    int          n_fail = 0;
    exp_t        sb[$];
    exp_t        cur;
    logic [23:0] path = '0;
    int          lat = 0;
    logic        pc_pend = 1'b0;
    logic [15:0] last_ir = 16'h0000;

    cpu_seq_ctrl_if #(.PC_W(16)) bus ();

    cpu_seq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .ir         (ir),
        .op_halt    (op_halt),
        .op_branch  (op_branch),
        .op_load    (op_load),
        .op_store   (op_store),
        .op_wr_rf   (op_wr_rf),
        .br_off     (br_off),
        .z_flag     (z_flag),
        .rf_we      (rf_we),
        .wb_sel_mem (wb_sel_mem),
        .pc_sync_we (pc_sync_we),
        .pc         (pc),
        .retire     (retire),
        .halted     (halted),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_imem();
        int n = 0;
        while (!bus.imem_req && n < 20) begin
            step();
            n++;
        end
        chk("imem_req_rise", bus.imem_req, 1);
    endtask

    // f = {halt, branch, load, store, wr_rf}
    task automatic issue(input logic [15:0] ins, input logic [4:0] f, input logic z,
                         input logic [10:0] off, input int iw, input int dw, input logic [15:0] pa,
                         input logic [23:0] ep, input int el, input logic erf, input logic ewb,
                         input logic [15:0] epc, input logic ehn);
        int n = 0;
        sb.push_back('{ins, ep, el, erf, ewb, epc, ehn});
        wait_imem();
        {op_halt, op_branch, op_load, op_store, op_wr_rf} = f;
        z_flag = z;
        br_off = off;
        for (int i = 0; i < iw; i++) begin
            bus.imem_ready = 1'b0;
            chk("fetch_hold", {bus.imem_req, bus.imem_addr, ir}, {1'b1, pa, last_ir});
            step();
        end
        bus.imem_ready = 1'b1;
        bus.imem_data = ins;
        chk("fetch_addr", {bus.imem_req, bus.imem_addr}, {1'b1, pa});
        step();
        bus.imem_ready = 1'b0;
        last_ir = ins;
        chk("decode_sync", {pc_sync_we, pc, ir}, {1'b1, pa + 16'd1, ins});
        if (!f[4] && !f[3] && (f[2] || f[1])) begin
            while (!bus.dmem_req && n < 20) begin
                step();
                n++;
            end
            for (int i = 0; i < dw; i++) begin
                chk("mem_hold", {bus.dmem_req, bus.dmem_we}, {1'b1, f[1]});
                step();
            end
            bus.dmem_ready = 1'b1;
            chk("mem_accept", {bus.dmem_req, bus.dmem_we}, {1'b1, f[1]});
            step();
            bus.dmem_ready = 1'b0;
        end
    endtask

    // monitor: tracks state path since fetch accept and checks each retire against the scoreboard
    always @(negedge clk) begin
        if (reset) begin
            pc_pend = 1'b0;
            path = '0;
            lat = 0;
        end else begin
            if (pc_pend) begin
                chk("pc_next", pc, cur.pcn);
                chk("halted_next", halted, cur.hn);
                pc_pend = 1'b0;
            end
            chk("excl", (rf_we & pc_sync_we) | (rf_we & bus.dmem_req) | (pc_sync_we & bus.dmem_req), 0);
            if (bus.imem_req && bus.imem_ready) begin
                path = '0;
                lat = 1;
            end else begin
                path = {path[20:0], state_dbg};
                lat++;
            end
            if (retire) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_retire: got retire with empty scoreboard, expected none");
                end else begin
                    cur = sb.pop_front();
                    chk("ret_ir", ir, cur.ir);
                    chk("ret_path", path, cur.path);
                    chk("ret_lat", lat, cur.lat);
                    chk("ret_rf_we", rf_we, cur.rf);
                    chk("ret_wb_sel", wb_sel_mem, cur.wbs);
                    pc_pend = 1'b1;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.imem_ready = 1'b0;
        bus.imem_data = 16'h0000;
        bus.dmem_ready = 1'b0;
        repeat (3) step();
        chk("reset_state", {state_dbg, pc, ir, bus.imem_req, bus.dmem_req, rf_we, pc_sync_we, retire, halted},
            {3'd0, 16'h0000, 16'h0000, 6'b000000});
        reset = 1'b0;
        // ALU with three wait cycles on fetch
        issue(16'h1111, 5'b00001, 0, 11'd0,   3, 0, 16'h0000, 24'o0124,    4, 1, 0, 16'h0001, 0);
        // load, data ready after two wait cycles
        issue(16'h2222, 5'b00100, 0, 11'd0,   0, 2, 16'h0001, 24'o0123334, 7, 1, 1, 16'h0002, 0);
        // store, zero wait
        issue(16'h3333, 5'b00010, 0, 11'd0,   0, 0, 16'h0002, 24'o0123,    4, 0, 0, 16'h0003, 0);
        // nop
        issue(16'h4444, 5'b00000, 0, 11'd0,   0, 0, 16'h0003, 24'o012,     3, 0, 0, 16'h0004, 0);
        // branch 5+10 -> 0x0F
        issue(16'h5555, 5'b01000, 1, 11'd10,  0, 0, 16'h0004, 24'o012,     3, 0, 0, 16'h000F, 0);
        // branch 0x10-2 -> 0x0E
        issue(16'h6666, 5'b01000, 1, 11'h7FE, 0, 0, 16'h000F, 24'o012,     3, 0, 0, 16'h000E, 0);
        issue(16'h7777, 5'b00000, 0, 11'd0,   0, 0, 16'h000E, 24'o012,     3, 0, 0, 16'h000F, 0);
        // not taken, pc stays at 0x10
        issue(16'h8888, 5'b01000, 0, 11'h7FE, 0, 0, 16'h000F, 24'o012,     3, 0, 0, 16'h0010, 0);
        // branch 0x11-18 -> 0xFFFF
        issue(16'h9999, 5'b01000, 1, 11'h7EE, 0, 0, 16'h0010, 24'o012,     3, 0, 0, 16'hFFFF, 0);
        // ALU at 0xFFFF, increment wraps
        issue(16'hAAAA, 5'b00001, 0, 11'd0,   0, 0, 16'hFFFF, 24'o0124,    4, 1, 0, 16'h0000, 0);
        // branch 1-3 -> 0xFFFE
        issue(16'hBBBB, 5'b01000, 1, 11'h7FD, 0, 0, 16'h0000, 24'o012,     3, 0, 0, 16'hFFFE, 0);
        // branch +1 from 0xFFFF wraps to 0
        issue(16'hCCCC, 5'b01000, 1, 11'd1,   0, 0, 16'hFFFE, 24'o012,     3, 0, 0, 16'h0000, 0);
        // branch beats load when both flags are set
        issue(16'hDDDD, 5'b01100, 0, 11'd5,   0, 0, 16'h0000, 24'o012,     3, 0, 0, 16'h0001, 0);
        // reset during a MEM wait
        wait_imem();
        {op_halt, op_branch, op_load, op_store, op_wr_rf} = 5'b00100;
        bus.imem_ready = 1'b1;
        bus.imem_data = 16'hEEEE;
        chk("rst_fetch_addr", bus.imem_addr, 16'h0001);
        step();
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 20 && !bus.dmem_req; i++) step();
        chk("rst_mem_req", bus.dmem_req, 1);
        step();
        step();
        reset = 1'b1;
        step();
        chk("rst_mid_mem", {bus.dmem_req, state_dbg, pc, ir, rf_we, retire, bus.imem_req},
            {1'b0, 3'd0, 16'h0000, 16'h0000, 3'b000});
        reset = 1'b0;
        last_ir = 16'h0000;
        // halt
        issue(16'hF00F, 5'b10000, 0, 11'd0,   0, 0, 16'h0000, 24'o012,     3, 0, 0, 16'h0001, 1);
        step();
        step();
        for (int i = 0; i < 20; i++) begin
            chk("halt_idle", {halted, bus.imem_req, bus.dmem_req, rf_we, pc_sync_we, retire, state_dbg, pc},
                {6'b100000, 3'd5, 16'h0001});
            step();
        end
        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
- Multi-cycle control sequencer for the 16-bit RISC core.
- Fetches instructions over a ready/valid instruction-memory port, holds the instruction register and owns the PC.
- Steps each instruction through DECODE, EXEC, MEM and WB, driving the register-file, data-memory and write-back controls that the decoder/ALU datapath consumes.
- Replaces the free-running two-state fetch toggle with a handshake-aware FSM.

Parameters:
- PC_W, 16, PC and instruction-address width.
- RESET_PC, 16'h0000, PC value loaded on reset.
- BR_W, 11, width of the signed branch offset (const11 field).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- imem_req  out  1  instruction fetch request; held until accepted
- imem_addr  out  PC_W  fetch address, equal to pc while imem_req is high
- imem_ready  in  1  fetch accepted; imem_data valid this cycle
- imem_data  in  16  fetched instruction
- ir  out  16  latched instruction register, drives the decoder
- op_halt  in  1  decoder: halt
- op_branch  in  1  decoder: conditional branch (taken when z_flag=1)
- op_load  in  1  decoder: load
- op_store  in  1  decoder: store
- op_wr_rf  in  1  decoder: ALU/shift/move result written to rf
- br_off  in  BR_W  signed branch offset
- z_flag  in  1  zero flag of the current result
- dmem_req  out  1  data-memory request; held until accepted
- dmem_we  out  1  store qualifier, valid while dmem_req is high
- dmem_ready  in  1  data access accepted / load data valid
- rf_we  out  1  register-file write enable (WB cycle)
- wb_sel_mem  out  1  1 = write-back data from dmem, 0 = from the result mux
- pc_sync_we  out  1  pulse; write pc into R15
- pc  out  PC_W  program counter
- retire  out  1  one-cycle pulse per completed instruction
- halted  out  1  core is in HALT
- state_dbg  out  3  state encoding, for the debug ports

Behaviour:
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. All registers update on the rising edge of clk only.
- Reset: state=FETCH, pc=RESET_PC, ir=16'h0000. All pulses and requests are low on the cycle after reset.
- Reset has priority over everything, including mid-MEM and mid-FETCH. Requests drop on the next cycle and no rf/pc write occurs.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - When imem_ready=1 (same-cycle ready is legal): ir<=imem_data, pc<=pc+1 (mod 2^PC_W), then go to DECODE.
  - Otherwise stay in FETCH with the request held.
- DECODE (1 cycle): pc_sync_we=1, so R15 receives the incremented pc. Go to EXEC.
- EXEC (1 cycle). Decoder flags are evaluated with priority halt > branch > load/store > wr_rf:
  - halt: go to HALT; retire=1.
  - branch: if z_flag=1, pc<=pc+sext(br_off) mod 2^PC_W. Go to FETCH; retire=1. Not taken: go to FETCH, pc unchanged.
  - load or store: go to MEM.
  - wr_rf: go to WB.
  - none of the above (nop): go to FETCH; retire=1.
- MEM:
  - dmem_req=1, dmem_we=op_store.
  - Hold the request until dmem_ready=1.
  - On ready: a store goes to FETCH with retire=1; a load goes to WB.
- WB (1 cycle): rf_we=1, wb_sel_mem=op_load. Go to FETCH; retire=1.
- HALT: all requests and write enables are 0, halted=1. Only reset exits HALT.
- rf_we, pc_sync_we and dmem_req are never asserted in the same cycle.
- Latency with zero-wait memories:
  - ALU op: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch or nop: 3 cycles.
- ir is stable from DECODE through WB, so the decoder outputs are stable as well.
- Illegal flag combinations are resolved by the priority order above.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - the state_t enum with the fixed encodings above;
  - the PC_W/BR_W defaults;
  - the RESET_PC constant.
- One sub-module, pc_unit, holds the pc register, the +1 incrementer and the sign-extend/add branch target. Its inputs are inc, br_take and br_off.
- The FSM stays in cpu_seq_ctrl.

Test Plan:
- Reset, then imem_ready=1 always with an ALU instruction (op_wr_rf=1): state sequence 0,1,2,4,0; rf_we high exactly in cycle 4; pc 0→1; pc_sync_we in cycle 2; retire in cycle 4.
- imem_ready held low 3 cycles: imem_req stays high with imem_addr=0 for 4 cycles; ir updates only on the ready cycle.
- Load with dmem_ready delayed 2 cycles: dmem_req/dmem_we=1/0 held 3 cycles; then WB with wb_sel_mem=1 and rf_we=1.
- pc=16'h0010 after fetch, branch with br_off=11'h7FE (-2), z_flag=1: pc=16'h000E at the next FETCH. With z_flag=0: pc=16'h0010.
- pc=16'hFFFF, ALU instruction fetched: pc wraps to 16'h0000. A branch with br_off=+1 from 16'hFFFF also yields 16'h0000.
- Halt: enters HALT and halted=1, with no requests for 20 cycles. Reset asserted during a MEM wait: dmem_req=0 the next cycle, state=FETCH, pc=RESET_PC.
